// File: rtl/pipe_fft_dly_line_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_fft_dly_line_if
// Brief    : Data/control bundle between a butterfly stage and its delay line.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_fft_dly_line_if #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 32
);
  localparam int AW = $clog2(DEPTH);

  logic             ce;
  logic             flush;
  logic [AW:0]      dly_len;
  logic             din_vld;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic             primed;
  logic             len_err;

  modport master (
    output ce, flush, dly_len, din_vld, din,
    input  dout, dout_vld, primed, len_err
  );

  modport slave (
    input  ce, flush, dly_len, din_vld, din,
    output dout, dout_vld, primed, len_err
  );
endinterface
`default_nettype wire

// File: rtl/pipe_fft_dly_line.sv
`default_nettype none
// ============================================================================
// Module   : pipe_fft_dly_line
// Brief    : Run-time length circular-buffer delay line for pipelined FFT
//            stages. Optional macro PIPEFFT_DLY_ZERO_FILL_EN zeroes dout
//            until the line is primed.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_fft_dly_line #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 32
) (
  input  logic                clk,
  input  logic                nGrst,
  pipe_fft_dly_line_if.slave  bus
);
  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_W   = (AW+1)'(1);

  logic [WIDTH:0]   mem_q [DEPTH];

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW:0]      len_q, len_d;
  logic [AW:0]      fill_q, fill_d;
  logic             primed_q, primed_d;
  logic             dout_vld_q, dout_vld_d;
  logic             len_err_q, len_err_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  logic             len_ok;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH:0]   wr_word;
  logic [WIDTH:0]   rd_word;

  assign len_ok  = (bus.dly_len != '0) && (bus.dly_len <= DEPTH_W);
  assign wr_word = {bus.din_vld, bus.din};

  // Oldest word still needed sits L-1 slots behind the write pointer; the
  // low bits of len_q are 0 when L=DEPTH, which wraps to wptr+1 as intended.
  assign rd_addr = wptr_q + AW'(1) - len_q[AW-1:0];
  assign rd_word = (len_q == ONE_W) ? wr_word : mem_q[rd_addr];

  always_comb begin
    wptr_d     = wptr_q;
    len_d      = len_q;
    fill_d     = fill_q;
    primed_d   = primed_q;
    dout_vld_d = dout_vld_q;
    len_err_d  = len_err_q;
    dout_d     = dout_q;

    if (bus.flush) begin
      wptr_d     = '0;
      fill_d     = '0;
      primed_d   = 1'b0;
      dout_vld_d = 1'b0;
      len_d      = len_ok ? bus.dly_len : DEPTH_W;
      len_err_d  = ~len_ok;
`ifdef PIPEFFT_DLY_ZERO_FILL_EN
      dout_d     = '0;
`endif
    end else if (bus.ce) begin
      wptr_d     = wptr_q + AW'(1);
      fill_d     = (fill_q == len_q) ? fill_q : fill_q + ONE_W;
      primed_d   = (fill_d == len_q);
      dout_vld_d = rd_word[WIDTH] & primed_d;
`ifdef PIPEFFT_DLY_ZERO_FILL_EN
      dout_d     = primed_d ? rd_word[WIDTH-1:0] : '0;
`else
      dout_d     = rd_word[WIDTH-1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      wptr_q     <= '0;
      len_q      <= DEPTH_W;
      fill_q     <= '0;
      primed_q   <= 1'b0;
      dout_vld_q <= 1'b0;
      len_err_q  <= 1'b0;
      dout_q     <= '0;
    end else begin
      wptr_q     <= wptr_d;
      len_q      <= len_d;
      fill_q     <= fill_d;
      primed_q   <= primed_d;
      dout_vld_q <= dout_vld_d;
      len_err_q  <= len_err_d;
      dout_q     <= dout_d;
    end
  end

  // Storage is deliberately left out of reset; dout_vld masks stale words.
  always_ff @(posedge clk) begin
    if (bus.ce && !bus.flush) begin
      mem_q[wptr_q] <= wr_word;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_vld = dout_vld_q;
  assign bus.primed   = primed_q;
  assign bus.len_err  = len_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_fft_dly_line.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_fft_dly_line
// Brief    : Directed self-checking bench for pipe_fft_dly_line.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_fft_dly_line;
  localparam int WIDTH = 66;
  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);

  logic clk;
  logic nGrst;
  int   total;
  int   bad;

  pipe_fft_dly_line_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pipe_fft_dly_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .nGrst (nGrst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one set of inputs across a rising edge, return 1 time unit after it.
  task automatic cyc(input logic c, input logic f, input logic [AW:0] l,
                     input logic v, input logic [WIDTH-1:0] d);
    bus.ce      = c;
    bus.flush   = f;
    bus.dly_len = l;
    bus.din_vld = v;
    bus.din     = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] hist [$];
    logic [WIDTH-1:0] last_dout;
    logic             last_vld;
    int               n;

    total = 0;
    bad   = 0;
    nGrst = 1'b0;
    bus.ce = 1'b0; bus.flush = 1'b0; bus.dly_len = '0; bus.din_vld = 1'b0; bus.din = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_dout", bus.dout, 0);
    chk("rst_vld", bus.dout_vld, 0);
    chk("rst_primed", bus.primed, 0);
    chk("rst_lenerr", bus.len_err, 0);
    nGrst = 1'b1;

    // T1: L=32, ramp of 80 words (wraps the pointer twice)
    cyc(1, 1, 32, 0, 0);
    chk("t1_flush_lenerr", bus.len_err, 0);
    for (int k = 1; k <= 80; k++) begin
      cyc(1, 0, 0, 1, WIDTH'(k));
      chk("t1_primed", bus.primed, (k >= 32) ? 1 : 0);
      chk("t1_vld", bus.dout_vld, (k >= 32) ? 1 : 0);
      if (k >= 32) chk("t1_dout", bus.dout, WIDTH'(k - 31));
    end

    // T2: L=1 behaves as a single register
    cyc(1, 1, 1, 0, 0);
    chk("t2_flush_primed", bus.primed, 0);
    for (int k = 1; k <= 5; k++) begin
      cyc(1, 0, 0, 1, WIDTH'(100 + k));
      chk("t2_primed", bus.primed, 1);
      chk("t2_dout", bus.dout, WIDTH'(100 + k));
      chk("t2_vld", bus.dout_vld, 1);
    end

    // T3: L=4 with ce toggling; outputs hold on ce=0 edges
    cyc(1, 1, 4, 0, 0);
    n = 0;
    last_dout = bus.dout;
    last_vld  = bus.dout_vld;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        n++;
        hist.push_back(WIDTH'(200 + i));
        cyc(1, 0, 0, 1, WIDTH'(200 + i));
        chk("t3_primed", bus.primed, (n >= 4) ? 1 : 0);
        if (n >= 4) chk("t3_dout", bus.dout, hist[n - 4]);
      end else begin
        cyc(0, 0, 0, 1, WIDTH'(999));
        chk("t3_hold_dout", bus.dout, last_dout);
        chk("t3_hold_vld", bus.dout_vld, last_vld);
      end
      last_dout = bus.dout;
      last_vld  = bus.dout_vld;
    end

    // T4: L=5 stream, flush mid-stream; flush-cycle word must never appear
    cyc(1, 1, 5, 0, 0);
    for (int k = 1; k <= 8; k++) cyc(1, 0, 0, 1, WIDTH'(300 + k));
    chk("t4_pre_dout", bus.dout, WIDTH'(304));
    chk("t4_pre_vld", bus.dout_vld, 1);
    cyc(1, 1, 5, 1, WIDTH'(777));
    chk("t4_flush_vld", bus.dout_vld, 0);
    chk("t4_flush_primed", bus.primed, 0);
    for (int m = 1; m <= 6; m++) begin
      cyc(1, 0, 0, 1, WIDTH'(400 + m));
      chk("t4_vld", bus.dout_vld, (m >= 5) ? 1 : 0);
      if (m >= 5) chk("t4_dout", bus.dout, WIDTH'(400 + m - 4));
    end

    // T5: illegal lengths fall back to DEPTH; legal length clears len_err
    cyc(1, 1, 0, 0, 0);
    chk("t5_lenerr0", bus.len_err, 1);
    for (int k = 1; k <= 32; k++) begin
      cyc(1, 0, 0, 1, WIDTH'(600 + k));
      if (k == 31) chk("t5_l0_primed31", bus.primed, 0);
    end
    chk("t5_l0_primed32", bus.primed, 1);
    chk("t5_l0_dout", bus.dout, WIDTH'(601));

    cyc(1, 1, 33, 0, 0);
    chk("t5_lenerr33", bus.len_err, 1);
    for (int k = 1; k <= 32; k++) begin
      cyc(1, 0, 0, 1, WIDTH'(650 + k));
      if (k == 31) chk("t5_l33_primed31", bus.primed, 0);
    end
    chk("t5_l33_primed32", bus.primed, 1);
    chk("t5_l33_dout", bus.dout, WIDTH'(651));

    cyc(1, 1, 8, 0, 0);
    chk("t5_lenerr8", bus.len_err, 0);
    for (int k = 1; k <= 10; k++) begin
      cyc(1, 0, 0, k[0], WIDTH'(700 + k));
      chk("t5_l8_primed", bus.primed, (k >= 8) ? 1 : 0);
      if (k >= 8) begin
        chk("t5_l8_dout", bus.dout, WIDTH'(700 + k - 7));
        chk("t5_l8_vld", bus.dout_vld, ((k - 7) % 2 == 1) ? 1 : 0);
      end
    end
    chk("t5_lenerr_hold", bus.len_err, 0);

    // T6: asynchronous reset between edges mid-stream
    cyc(1, 1, 3, 0, 0);
    for (int k = 1; k <= 5; k++) cyc(1, 0, 0, 1, WIDTH'(800 + k));
    chk("t6_pre_dout", bus.dout, WIDTH'(803));
    #2;
    nGrst = 1'b0;
    #1;
    chk("t6_async_dout", bus.dout, 0);
    chk("t6_async_vld", bus.dout_vld, 0);
    chk("t6_async_primed", bus.primed, 0);
    #1;
    nGrst = 1'b1;
    // No flush: length returns to DEPTH after reset
    for (int k = 1; k <= 32; k++) begin
      cyc(1, 0, 0, 1, WIDTH'(500 + k));
      chk("t6_vld", bus.dout_vld, (k >= 32) ? 1 : 0);
`ifdef PIPEFFT_DLY_ZERO_FILL_EN
      if (k < 32) chk("t6_zero_fill", bus.dout, 0);
`endif
    end
    chk("t6_primed", bus.primed, 1);
    chk("t6_dout", bus.dout, WIDTH'(501));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
